// File: rtl/addr_decoder_mc.sv
// addr_decoder_mc: multi-region address decoder with per-region wait states,
// busy/ack handshake and an error response for unmapped addresses.
module addr_decoder_mc #(
    parameter int ADDR_W = 32,
    parameter int OFF_W = 10,
    parameter int NREG = 4,
    parameter logic [NREG*ADDR_W-1:0] BASES = {32'h4000, 32'h2AB0, 32'h26B0, 32'h22B0},
    parameter logic [NREG*4-1:0] WAITS = {4'd0, 4'd3, 4'd1, 4'd0}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    input  logic              we_ctrl,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [NREG-1:0]   cs,
    output logic              we,
    output logic [OFF_W-1:0]  address_out
);
    localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n, hwait;
    logic [IW-1:0] idx, idx_n, hidx;
    logic [OFF_W-1:0] off, off_n, hoff, aout_n;
    logic [ADDR_W-1:0] diff;
    logic [NREG-1:0] cs_n;
    logic wr, wr_n, hit, sel_n, busy_n, ack_n, err_n, we_n;
    // Scan from the top index down so the lowest matching region wins on overlap
    always_comb begin
        hit = 1'b0;
        hidx = '0;
        hoff = '0;
        diff = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            diff = address - BASES[i*ADDR_W +: ADDR_W];
            if (address >= BASES[i*ADDR_W +: ADDR_W] && diff[ADDR_W-1:OFF_W] == '0) begin
                hit = 1'b1;
                hidx = IW'(i);
                hoff = diff[OFF_W-1:0];
            end
        end
        hwait = WAITS[4*int'(hidx) +: 4];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            idx <= '0;
            off <= '0;
            wr <= 1'b0;
            busy <= 1'b0;
            ack <= 1'b0;
            err <= 1'b0;
            cs <= '0;
            we <= 1'b0;
            address_out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            off <= off_n;
            wr <= wr_n;
            busy <= busy_n;
            ack <= ack_n;
            err <= err_n;
            cs <= cs_n;
            we <= we_n;
            address_out <= aout_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        off_n = off;
        wr_n = wr;
        case (state)
            S_IDLE: if (req) begin
                idx_n = hidx;
                off_n = hoff;
                wr_n = we_ctrl;
                cnt_n = hwait == 4'd0 ? 4'd0 : hwait - 4'd1;
                state_n = !hit ? S_ERR : hwait == 4'd0 ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                state_n = cnt == 4'd0 ? S_ACK : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they land in registers
    always_comb begin
        sel_n = state_n == S_WAIT || state_n == S_ACK;
        busy_n = state_n != S_IDLE;
        ack_n = state_n == S_ACK || state_n == S_ERR;
        err_n = state_n == S_ERR;
        we_n = state_n == S_ACK && wr_n;
        cs_n = sel_n ? NREG'(1) << idx_n : '0;
        aout_n = sel_n ? off_n : '0;
    end
endmodule
